// File: rtl/fsk_serializer.sv
// Parallel-to-serial framer feeding fsk_modulator: start, LSB-first payload, optional parity, stop.
// Define FSK_SER_PARITY_EN to insert an even-parity bit between the payload and the stop bits.
module fsk_serializer #(
  parameter int DATA_W       = 12,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic              sysclk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              signal_tx,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

`ifdef FSK_SER_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t            state;
  logic [DATA_W-1:0] shift;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  bit_idx;
  logic              stop_idx;
  logic              bit_end;
`ifdef FSK_SER_PARITY_EN
  logic              parity;
`endif

  assign bit_end = (cnt == CNT_LAST);

  // Every non-idle state holds its line level for one full bit time, then advances on bit_end.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift     <= '0;
      cnt       <= '0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      signal_tx <= 1'b1;
      tx_ready  <= 1'b0;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
`ifdef FSK_SER_PARITY_EN
      parity    <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          signal_tx <= 1'b1;
          tx_busy   <= 1'b0;
          cnt       <= '0;
          bit_idx   <= '0;
          stop_idx  <= 1'b0;
          if (tx_valid && tx_ready) begin
            shift     <= tx_data;
`ifdef FSK_SER_PARITY_EN
            parity    <= ^tx_data;
`endif
            state     <= START;
            signal_tx <= 1'b0;
            tx_ready  <= 1'b0;
            tx_busy   <= 1'b1;
          end else begin
            tx_ready <= 1'b1;
          end
        end

        START: begin
          cnt <= bit_end ? '0 : cnt + 1'b1;
          if (bit_end) begin
            state     <= DATA;
            signal_tx <= shift[0];
          end
        end

        DATA: begin
          cnt <= bit_end ? '0 : cnt + 1'b1;
          if (bit_end) begin
            if (bit_idx == IDX_LAST) begin
              bit_idx <= '0;
`ifdef FSK_SER_PARITY_EN
              state     <= PARITY;
              signal_tx <= parity;
`else
              state     <= STOP;
              signal_tx <= 1'b1;
`endif
            end else begin
              // shift[1] is the bit that lands in shift[0] after this shift
              shift     <= shift >> 1;
              signal_tx <= shift[1];
              bit_idx   <= bit_idx + 1'b1;
            end
          end
        end

`ifdef FSK_SER_PARITY_EN
        PARITY: begin
          cnt <= bit_end ? '0 : cnt + 1'b1;
          if (bit_end) begin
            state     <= STOP;
            signal_tx <= 1'b1;
          end
        end
`endif

        STOP: begin
          cnt       <= bit_end ? '0 : cnt + 1'b1;
          signal_tx <= 1'b1;
          if (bit_end) begin
            if (stop_idx == STOP_LAST) begin
              state    <= IDLE;
              stop_idx <= 1'b0;
              tx_done  <= 1'b1;
              tx_ready <= 1'b1;
              tx_busy  <= 1'b0;
            end else begin
              stop_idx <= stop_idx + 1'b1;
            end
          end
        end

        default: begin
          state     <= IDLE;
          signal_tx <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsk_serializer.sv
// Self-checking bench for fsk_serializer: table-driven frames plus reset, back-to-back and data-stability sequences.
// Expected frame values follow the FSK_SER_PARITY_EN setting used for the build.
module tb_fsk_serializer;

  localparam int DW  = 12;
  localparam int CPB = 16;
`ifdef FSK_SER_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NSLOT = 2 + DW + P;
  localparam int FRAME = NSLOT * CPB;

  logic          sysclk;
  logic          rst_n;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          signal_tx;
  logic          tx_busy;
  logic          tx_done;

  int tests;
  int fails;
  int last_wait;

  typedef struct {
    logic [11:0] data;
    logic [15:0] exp_np;
    logic [15:0] exp_p;
  } vec_t;

  vec_t        vecs[5];
  logic [15:0] bits;

  fsk_serializer #(
    .DATA_W(DW),
    .CLKS_PER_BIT(CPB),
    .STOP_BITS(1)
  ) dut (
    .sysclk(sysclk),
    .rst_n(rst_n),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .signal_tx(signal_tx),
    .tx_busy(tx_busy),
    .tx_done(tx_done)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Called at a negedge; offers a word, follows the whole frame and ends at the tx_done cycle's negedge.
  task automatic apply_stimulus(input logic [11:0] data, input bit scramble, input bit hold,
                                input logic [11:0] next_data, output logic [15:0] slots);
    int   waited;
    bit   glitch, busy_bad, done_early;
    logic prev;
    tx_data  = data;
    tx_valid = 1'b1;
    waited   = 0;
    while (!tx_ready && waited < 20) begin
      @(negedge sysclk);
      waited++;
    end
    last_wait = waited;
    check_output("ready_timeout", 32'(waited < 20), 32'd1);
    @(posedge sysclk);
    #1;
    tx_valid = hold;
    if (hold) tx_data = next_data;
    slots      = '0;
    glitch     = 1'b0;
    busy_bad   = 1'b0;
    done_early = 1'b0;
    prev       = 1'b1;
    for (int k = 0; k < FRAME; k++) begin
      @(negedge sysclk);
      if (scramble) tx_data = 12'($urandom);
      if (k % CPB == CPB / 2) slots[k / CPB] = signal_tx;
      if (k % CPB != 0 && signal_tx !== prev) glitch = 1'b1;
      prev = signal_tx;
      if (tx_busy !== 1'b1) busy_bad = 1'b1;
      if (tx_done !== 1'b0 || tx_ready !== 1'b0) done_early = 1'b1;
    end
    @(negedge sysclk);
    check_output("bit_hold_stable", 32'(glitch), 32'd0);
    check_output("busy_in_frame", 32'(busy_bad), 32'd0);
    check_output("done_or_ready_early", 32'(done_early), 32'd0);
    check_output("done_at_frame_end", 32'(tx_done), 32'd1);
    check_output("ready_at_frame_end", 32'(tx_ready), 32'd1);
    check_output("busy_clear_at_end", 32'(tx_busy), 32'd0);
    check_output("line_idle_at_end", 32'(signal_tx), 32'd1);
  endtask

  initial begin
    bit bad;
    tests    = 0;
    fails    = 0;
    rst_n    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;

    // Frame images: slot 0 is bit 0, start=0, LSB-first payload, parity (if built), stop=1.
    vecs[0] = '{12'hA5C, 16'h34B8, 16'h54B8};
    vecs[1] = '{12'h001, 16'h2002, 16'h6002};
    vecs[2] = '{12'hFFF, 16'h3FFE, 16'h5FFE};
    vecs[3] = '{12'h000, 16'h2000, 16'h4000};
    vecs[4] = '{12'h555, 16'h2AAA, 16'h4AAA};

    #23;
    check_output("rst_line", 32'(signal_tx), 32'd1);
    check_output("rst_ready", 32'(tx_ready), 32'd0);
    check_output("rst_busy", 32'(tx_busy), 32'd0);
    check_output("rst_done", 32'(tx_done), 32'd0);

    @(negedge sysclk);
    rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge sysclk);
      if (signal_tx !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0 || tx_ready !== 1'b1) bad = 1'b1;
    end
    check_output("idle_after_release", 32'(bad), 32'd0);

    for (int i = 0; i < 5; i++) begin
      apply_stimulus(vecs[i].data, 1'b0, 1'b0, 12'h000, bits);
      check_output($sformatf("frame_%03h", vecs[i].data), 32'(bits), 32'(P ? vecs[i].exp_p : vecs[i].exp_np));
      repeat (3) @(negedge sysclk);
    end

    // tx_data scrambled every cycle after acceptance must not leak into the frame.
    apply_stimulus(12'h3C6, 1'b1, 1'b0, 12'h000, bits);
    check_output("frame_scrambled_3c6", 32'(bits), P ? 32'h478C : 32'h278C);
    repeat (2) @(negedge sysclk);

    // Back-to-back: valid held high, second word taken on the tx_done cycle.
    apply_stimulus(12'h0FF, 1'b0, 1'b1, 12'hF00, bits);
    check_output("frame_b2b_0ff", 32'(bits), P ? 32'h41FE : 32'h21FE);
    apply_stimulus(12'hF00, 1'b0, 1'b0, 12'h000, bits);
    check_output("b2b_accept_wait", 32'(last_wait), 32'd0);
    check_output("frame_b2b_f00", 32'(bits), P ? 32'h5E00 : 32'h3E00);
    repeat (2) @(negedge sysclk);

    // Reset 100 cycles into a frame whose payload bit 5 is low on the line.
    tx_data  = 12'h7D5;
    tx_valid = 1'b1;
    @(posedge sysclk);
    #1;
    tx_valid = 1'b0;
    repeat (100) @(negedge sysclk);
    check_output("pre_reset_line_low", 32'(signal_tx), 32'd0);
    rst_n = 1'b0;
    #1;
    check_output("midframe_rst_line", 32'(signal_tx), 32'd1);
    check_output("midframe_rst_busy", 32'(tx_busy), 32'd0);
    repeat (3) @(negedge sysclk);
    rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge sysclk);
      if (tx_done !== 1'b0 || signal_tx !== 1'b1) bad = 1'b1;
    end
    check_output("no_done_after_abort", 32'(bad), 32'd0);
    apply_stimulus(12'h555, 1'b0, 1'b0, 12'h000, bits);
    check_output("frame_after_reset_555", 32'(bits), P ? 32'h4AAA : 32'h2AAA);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fsk_serializer.md
Name: fsk_serializer

Overview:
- Parallel-to-serial framer directly upstream of fsk_modulator.
- Accepts a 12-bit word over a valid/ready handshake and drives the modulator's serial input (signal_in) with a framed, LSB-first bit stream.
- Each bit is held for CLKS_PER_BIT sysclk cycles; the line idles high.
- Framing matches the deserializer at the receive end of the modem chain, so a transmitted word reappears on RX_Data.

Parameters:
- DATA_W, 12, payload bits per frame.
- CLKS_PER_BIT, 16, sysclk cycles per serial bit; legal values are 2 or more.
- STOP_BITS, 1, number of stop bits (high); legal values are 1 or 2.

Ports:
- sysclk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- tx_data  input  DATA_W  word to transmit; sampled only on handshake.
- tx_valid  input  1  upstream has a word on tx_data.
- tx_ready  output  1  block can accept a word this cycle.
- signal_tx  output  1  serial line; connects to fsk_modulator signal_in.
- tx_busy  output  1  frame in progress (any state other than IDLE).
- tx_done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset is asynchronous and active-low; the block has one clock.
- Reset values: signal_tx=1, tx_ready=0, tx_busy=0, tx_done=0, state=IDLE, all counters 0.
- tx_ready rises on the first sysclk edge after rst_n deasserts.
- All outputs are registered.
- States are IDLE, START, DATA, PARITY (only with the optional feature), STOP.
- IDLE: tx_ready=1, signal_tx=1.
- Acceptance: a rising edge with tx_valid=1 and tx_ready=1 accepts the word. On that edge:
  - tx_data is latched into the shift register.
  - state goes to START; signal_tx goes to 0.
  - tx_ready goes to 0; tx_busy goes to 1.
- Word stability: tx_data changes after the acceptance edge have no effect on the frame in flight.
- Bit timing: a cycle counter runs 0..CLKS_PER_BIT-1.
  - Every bit, including start, parity and stop, is held for exactly CLKS_PER_BIT cycles.
  - The counter is $clog2(CLKS_PER_BIT) bits wide and wraps to 0 at the end of each bit.
- START: after one bit time, go to DATA and drive shift[0].
- DATA: on each bit boundary, shift right and drive the next bit (LSB first).
  - A bit index counts 0..DATA_W-1.
  - After bit DATA_W-1, go to PARITY if enabled, else to STOP.
- STOP: signal_tx=1 for STOP_BITS×CLKS_PER_BIT cycles. On the final boundary:
  - state goes to IDLE.
  - tx_done=1 for exactly one cycle; tx_ready=1 and tx_busy=0 in that same cycle.
- Frame length: from the acceptance edge to the return-to-IDLE edge is (1+DATA_W+P+STOP_BITS)×CLKS_PER_BIT cycles, with P=1 if parity is enabled, else 0.
  - Defaults without parity: 14×16 = 224 cycles.
- Back-to-back frames: a word offered while tx_valid is held high is accepted in the first IDLE cycle (the tx_done cycle).
  - The next start bit follows immediately, with no extra idle bit time.
- tx_valid without tx_ready: no effect; the word stays pending upstream.
- Reset mid-frame: signal_tx returns high immediately (asynchronously) and the frame is discarded; no tx_done is issued.

Optional Feature:
- Macro: FSK_SER_PARITY_EN.
- Defined: a PARITY state follows DATA and drives the even-parity bit (XOR of all DATA_W payload bits) for one bit time. The frame grows by CLKS_PER_BIT cycles.
- Undefined: the PARITY state and XOR logic are absent, and DATA goes directly to STOP.
- The receive-side deserializer must be built with the same setting.

Test Plan:
- Reset release, tx_valid=0 for 50 cycles -> signal_tx=1, tx_busy=0 and tx_done=0 throughout; tx_ready=1 from the first edge after release.
- Send tx_data=12'hA5C, defaults, no parity:
  - signal_tx sequence per 16-cycle slot is 0, then 0,0,1,1,1,0,1,0,0,1,0,1, then 1.
  - tx_done pulses exactly 224 cycles after acceptance.
- Parity enabled, 12'hA5C -> parity slot=0. Parity enabled, 12'h001 -> parity slot=1. Frame length 240 cycles in both cases.
- tx_valid held high with words 12'h0FF then 12'hF00:
  - The second word is accepted on the tx_done cycle.
  - Its start bit follows the first frame's stop bit with zero idle cycles.
- Change tx_data every cycle after acceptance -> the transmitted bits match the latched word only.
- Assert rst_n=0 at cycle 100 of a frame:
  - signal_tx=1 immediately and no tx_done.
  - After release, a new word 12'h555 is sent correctly and, through the modulator, demodulator and deserializer chain, appears as RX_Data=12'h555.
